// File: rtl/flash_arbiter.sv
// rtl/flash_arbiter.sv - shares one flash read port between CPU word reads and a sequential DMA stream
module flash_arbiter #(
    parameter int ADDR_WIDTH = 24,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_read_en,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    output logic [31:0]           cpu_read_data,
    output logic                  cpu_read_ready,
    input  logic                  dma_start,
    input  logic [ADDR_WIDTH-1:0] dma_address,
    input  logic [LEN_WIDTH-1:0]  dma_length,
    output logic                  dma_busy,
    output logic [31:0]           dma_data,
    output logic                  dma_data_valid,
    input  logic                  dma_data_ready,
    output logic                  dma_done,
    output logic                  mem_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_continue,
    input  logic                  mem_ready,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        DMA_RD = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

    state_t                  state;
    state_t                  state_next;
    logic                    cpu_read_en_q;
    logic                    cpu_pending;
    logic [ADDR_WIDTH-1:0]   cpu_addr_q;
    logic [ADDR_WIDTH-1:0]   dma_addr_q;
    logic [LEN_WIDTH-1:0]    dma_remaining;
    logic                    last_grant_cpu;
    logic                    hist_valid;
    logic [ADDR_WIDTH-1:0]   last_addr;
    logic                    cpu_rise;
    logic                    dma_handshake;
    logic                    dma_eligible;
    logic                    dma_start_ok;
    logic                    mem_done;
    logic                    grant_cpu;
    logic                    grant_dma;
    logic [ADDR_WIDTH-1:0]   grant_addr;

    assign cpu_rise      = cpu_read_en && !cpu_read_en_q;
    assign dma_handshake = dma_data_valid && dma_data_ready;
    assign dma_start_ok  = dma_start && !dma_busy;
    assign mem_done      = mem_valid && mem_ready;
    // A word may be fetched only if the single output slot is free by the time it returns.
    assign dma_eligible  = dma_busy && (dma_remaining != '0) && (!dma_data_valid || dma_data_ready);
    assign grant_addr    = grant_cpu ? cpu_addr_q : dma_addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_cpu  = 1'b0;
        grant_dma  = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_pending && !(last_grant_cpu && dma_eligible)) begin
                    grant_cpu  = 1'b1;
                    state_next = CPU_RD;
                end else if (dma_eligible) begin
                    grant_dma  = 1'b1;
                    state_next = DMA_RD;
                end
            end
            CPU_RD: begin
                if (mem_ready) begin
                    state_next = IDLE;
                end
            end
            DMA_RD: begin
                if (mem_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_read_en_q  <= 1'b0;
            cpu_pending    <= 1'b0;
            cpu_addr_q     <= '0;
            cpu_read_data  <= '0;
            cpu_read_ready <= 1'b0;
            dma_addr_q     <= '0;
            dma_remaining  <= '0;
            dma_busy       <= 1'b0;
            dma_data       <= '0;
            dma_data_valid <= 1'b0;
            dma_done       <= 1'b0;
            mem_valid      <= 1'b0;
            mem_addr       <= '0;
            mem_continue   <= 1'b0;
            last_grant_cpu <= 1'b0;
            hist_valid     <= 1'b0;
            last_addr      <= '0;
        end else begin
            cpu_read_en_q  <= cpu_read_en;
            cpu_read_ready <= 1'b0;
            dma_done       <= 1'b0;

            if (cpu_rise && !cpu_pending) begin
                cpu_pending <= 1'b1;
                cpu_addr_q  <= cpu_address & WORD_MASK;
            end

            if (grant_cpu || grant_dma) begin
                mem_valid      <= 1'b1;
                mem_addr       <= grant_addr;
                mem_continue   <= hist_valid && (grant_addr == last_addr + WORD_STEP);
                last_grant_cpu <= grant_cpu;
            end

            if (mem_done) begin
                mem_valid    <= 1'b0;
                mem_continue <= 1'b0;
                hist_valid   <= 1'b1;
                last_addr    <= mem_addr;
            end

            if (mem_done && state == CPU_RD) begin
                cpu_read_data  <= mem_rdata;
                cpu_read_ready <= 1'b1;
                cpu_pending    <= 1'b0;
            end

            if (dma_handshake) begin
                dma_data_valid <= 1'b0;
            end

            if (mem_done && state == DMA_RD) begin
                dma_data       <= mem_rdata;
                dma_data_valid <= 1'b1;
                dma_addr_q     <= dma_addr_q + WORD_STEP;
                dma_remaining  <= dma_remaining - LEN_WIDTH'(1);
            end

            if (dma_busy && dma_remaining == '0 && dma_handshake) begin
                dma_busy <= 1'b0;
                dma_done <= 1'b1;
            end

            // Busy is low here, so this never collides with the final-word branch above.
            if (dma_start_ok) begin
                if (dma_length == '0) begin
                    dma_done <= 1'b1;
                end else begin
                    dma_busy      <= 1'b1;
                    dma_addr_q    <= dma_address & WORD_MASK;
                    dma_remaining <= dma_length;
                end
            end
        end
    end

endmodule

// File: tb/tb_flash_arbiter.sv
// tb/tb_flash_arbiter.sv - scoreboard bench for flash_arbiter with a fixed-latency flash model
module tb_flash_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_read_en;
    logic [23:0] cpu_address;
    logic [31:0] cpu_read_data;
    logic        cpu_read_ready;
    logic        dma_start;
    logic [23:0] dma_address;
    logic [15:0] dma_length;
    logic        dma_busy;
    logic [31:0] dma_data;
    logic        dma_data_valid;
    logic        dma_data_ready;
    logic        dma_done;
    logic        mem_valid;
    logic [23:0] mem_addr;
    logic        mem_continue;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    flash_arbiter #(.ADDR_WIDTH(24), .LEN_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .cpu_read_en(cpu_read_en), .cpu_address(cpu_address),
        .cpu_read_data(cpu_read_data), .cpu_read_ready(cpu_read_ready),
        .dma_start(dma_start), .dma_address(dma_address), .dma_length(dma_length),
        .dma_busy(dma_busy), .dma_data(dma_data), .dma_data_valid(dma_data_valid),
        .dma_data_ready(dma_data_ready), .dma_done(dma_done),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_continue(mem_continue),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int unstable = 0;
    int done_cnt = 0;
    int lat_cfg = 2;

    logic [31:0] exp_cpu[$];
    logic [31:0] obs_cpu[$];
    logic [31:0] exp_dma[$];
    logic [31:0] obs_dma[$];
    logic [24:0] exp_mem[$];
    logic [24:0] obs_mem[$];
    logic [24:0] e25, o25;
    logic [31:0] e32, o32;

    function automatic logic [31:0] flash_word(input logic [23:0] a);
        if (a == 24'h100010) return 32'hDEADBEEF;
        return {8'h5A, a} ^ 32'h0013_0F0F;
    endfunction

    // Flash controller model: answers each request lat_cfg cycles after first seeing it.
    initial begin : flash_model
        int wait_cnt;
        logic [23:0] req_addr;
        logic req_cont;
        wait_cnt = 0; req_addr = '0; req_cont = 1'b0;
        mem_ready = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (reset || !mem_valid) begin
                wait_cnt = 0;
            end else begin
                if (wait_cnt == 0) begin
                    req_addr = mem_addr;
                    req_cont = mem_continue;
                end else if (mem_addr !== req_addr || mem_continue !== req_cont) begin
                    unstable++;
                end
                if (wait_cnt == lat_cfg) begin
                    mem_ready = 1'b1;
                    mem_rdata = flash_word(req_addr);
                    obs_mem.push_back({req_cont, req_addr});
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (dma_data_valid && dma_data_ready) obs_dma.push_back(dma_data);
            if (cpu_read_ready) obs_cpu.push_back(cpu_read_data);
            if (dma_done) done_cnt++;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; cpu_read_en = 1'b0; cpu_address = '0;
        dma_start = 1'b0; dma_address = '0; dma_length = '0; dma_data_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_cpu.delete(); obs_cpu.delete(); exp_dma.delete(); obs_dma.delete();
        exp_mem.delete(); obs_mem.delete();
        done_cnt = 0; unstable = 0;
    endtask

    task automatic cpu_read(input logic [23:0] a, output bit ok, output int lat);
        @(posedge clk); #1;
        cpu_address = a; cpu_read_en = 1'b1;
        exp_cpu.push_back(flash_word(a & 24'hFFFFFC));
        ok = 1'b0; lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (lat < 0 && mem_valid && mem_addr == (a & 24'hFFFFFC)) lat = i;
            if (cpu_read_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        cpu_read_en = 1'b0;
    endtask

    task automatic start_dma(input logic [23:0] a, input logic [15:0] n, input bit expect_accept);
        @(posedge clk); #1;
        dma_start = 1'b1; dma_address = a; dma_length = n;
        if (expect_accept)
            for (int k = 0; k < int'(n); k++) exp_dma.push_back(flash_word(a + 24'(4 * k)));
        @(posedge clk); #1;
        dma_start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (dma_done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        vectors++;
        if ({mem_valid, mem_continue, cpu_read_ready, dma_busy, dma_data_valid, dma_done} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b want 000000",
                     {mem_valid, mem_continue, cpu_read_ready, dma_busy, dma_data_valid, dma_done});
        end
        vectors++;
        if ({cpu_read_data, dma_data} !== 64'b0) begin
            miscompares++;
            $display("FAIL reset_data got %h want 0", {cpu_read_data, dma_data});
        end
    endtask

    task automatic test_cpu_only();
        bit ok; int lat;
        do_reset();
        exp_mem.push_back({1'b0, 24'h100010});
        exp_mem.push_back({1'b1, 24'h100014});
        cpu_read(24'h100010, ok, lat);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL cpu_only_timeout got none want cpu_read_ready"); end
        vectors++;
        if (lat !== 2) begin miscompares++; $display("FAIL cpu_only_latency got %0d want 2", lat); end
        @(negedge clk);
        vectors++;
        if (cpu_read_data !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL cpu_only_data got %h want deadbeef", cpu_read_data);
        end
        cpu_read(24'h100016, ok, lat);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL cpu_seq_timeout got none want cpu_read_ready"); end
        repeat (3) @(negedge clk);
        vectors++;
        if (obs_mem.size() != exp_mem.size()) begin
            miscompares++; $display("FAIL cpu_mem_count got %0d want %0d", obs_mem.size(), exp_mem.size());
        end
        while (exp_mem.size() > 0 && obs_mem.size() > 0) begin
            e25 = exp_mem.pop_front(); o25 = obs_mem.pop_front(); vectors++;
            if (o25 !== e25) begin
                miscompares++;
                $display("FAIL cpu_mem got cont=%b addr=%h want cont=%b addr=%h", o25[24], o25[23:0], e25[24], e25[23:0]);
            end
        end
        vectors++;
        if (obs_cpu.size() != exp_cpu.size()) begin
            miscompares++; $display("FAIL cpu_resp_count got %0d want %0d", obs_cpu.size(), exp_cpu.size());
        end
        while (exp_cpu.size() > 0 && obs_cpu.size() > 0) begin
            e32 = exp_cpu.pop_front(); o32 = obs_cpu.pop_front(); vectors++;
            if (o32 !== e32) begin miscompares++; $display("FAIL cpu_resp got %h want %h", o32, e32); end
        end
    endtask

    task automatic test_dma_burst();
        bit ok;
        do_reset();
        for (int k = 0; k < 4; k++) exp_mem.push_back({k != 0, 24'h100000 + 24'(4 * k)});
        start_dma(24'h100000, 16'd4, 1'b1);
        @(negedge clk);
        vectors++;
        if (dma_busy !== 1'b1) begin miscompares++; $display("FAIL burst_busy got %b want 1", dma_busy); end
        wait_done(200, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL burst_timeout got none want dma_done"); end
        vectors++;
        if (dma_busy !== 1'b0) begin miscompares++; $display("FAIL burst_busy_at_done got %b want 0", dma_busy); end
        repeat (3) @(negedge clk);
        vectors++;
        if (done_cnt !== 1) begin miscompares++; $display("FAIL burst_done_count got %0d want 1", done_cnt); end
        vectors++;
        if (obs_mem.size() != exp_mem.size()) begin
            miscompares++; $display("FAIL burst_mem_count got %0d want %0d", obs_mem.size(), exp_mem.size());
        end
        while (exp_mem.size() > 0 && obs_mem.size() > 0) begin
            e25 = exp_mem.pop_front(); o25 = obs_mem.pop_front(); vectors++;
            if (o25 !== e25) begin
                miscompares++;
                $display("FAIL burst_mem got cont=%b addr=%h want cont=%b addr=%h", o25[24], o25[23:0], e25[24], e25[23:0]);
            end
        end
        vectors++;
        if (obs_dma.size() != exp_dma.size()) begin
            miscompares++; $display("FAIL burst_word_count got %0d want %0d", obs_dma.size(), exp_dma.size());
        end
        while (exp_dma.size() > 0 && obs_dma.size() > 0) begin
            e32 = exp_dma.pop_front(); o32 = obs_dma.pop_front(); vectors++;
            if (o32 !== e32) begin miscompares++; $display("FAIL burst_word got %h want %h", o32, e32); end
        end
        vectors++;
        if (unstable !== 0) begin miscompares++; $display("FAIL burst_stable got %0d changes want 0", unstable); end
    endtask

    task automatic test_contention();
        bit ok; int lat;
        do_reset();
        exp_mem.push_back({1'b0, 24'h100000});
        exp_mem.push_back({1'b0, 24'h180000});
        exp_mem.push_back({1'b0, 24'h100004});
        exp_mem.push_back({1'b1, 24'h100008});
        exp_mem.push_back({1'b1, 24'h10000C});
        start_dma(24'h100000, 16'd4, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_valid) begin ok = 1'b1; break; end
        end
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL cont_first_req got none want mem_valid"); end
        cpu_read(24'h180000, ok, lat);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL cont_cpu_timeout got none want cpu_read_ready"); end
        wait_done(200, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL cont_dma_timeout got none want dma_done"); end
        repeat (3) @(negedge clk);
        vectors++;
        if (obs_mem.size() != exp_mem.size()) begin
            miscompares++; $display("FAIL cont_mem_count got %0d want %0d", obs_mem.size(), exp_mem.size());
        end
        while (exp_mem.size() > 0 && obs_mem.size() > 0) begin
            e25 = exp_mem.pop_front(); o25 = obs_mem.pop_front(); vectors++;
            if (o25 !== e25) begin
                miscompares++;
                $display("FAIL cont_mem got cont=%b addr=%h want cont=%b addr=%h", o25[24], o25[23:0], e25[24], e25[23:0]);
            end
        end
        while (exp_dma.size() > 0 && obs_dma.size() > 0) begin
            e32 = exp_dma.pop_front(); o32 = obs_dma.pop_front(); vectors++;
            if (o32 !== e32) begin miscompares++; $display("FAIL cont_word got %h want %h", o32, e32); end
        end
        vectors++;
        if (exp_dma.size() + obs_dma.size() != 0) begin
            miscompares++; $display("FAIL cont_word_left got %0d/%0d want 0/0", obs_dma.size(), exp_dma.size());
        end
        e32 = exp_cpu.pop_front(); vectors++;
        if (cpu_read_data !== e32) begin miscompares++; $display("FAIL cont_cpu_data got %h want %h", cpu_read_data, e32); end
    endtask

    task automatic test_backpressure();
        bit ok; int lat;
        do_reset();
        dma_data_ready = 1'b0;
        exp_mem.push_back({1'b0, 24'h140000});
        exp_mem.push_back({1'b0, 24'h150000});
        exp_mem.push_back({1'b0, 24'h140004});
        exp_mem.push_back({1'b1, 24'h140008});
        start_dma(24'h140000, 16'd3, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dma_data_valid) begin ok = 1'b1; break; end
        end
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL bp_first_word got none want dma_data_valid"); end
        cpu_read(24'h150000, ok, lat);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL bp_cpu_timeout got none want cpu_read_ready"); end
        repeat (10) @(negedge clk);
        vectors++;
        if (obs_mem.size() !== 2 || mem_valid !== 1'b0) begin
            miscompares++; $display("FAIL bp_stall got %0d accesses mem_valid=%b want 2 accesses mem_valid=0", obs_mem.size(), mem_valid);
        end
        vectors++;
        if (dma_data_valid !== 1'b1 || dma_data !== flash_word(24'h140000)) begin
            miscompares++; $display("FAIL bp_hold got valid=%b data=%h want valid=1 data=%h", dma_data_valid, dma_data, flash_word(24'h140000));
        end
        e32 = exp_cpu.pop_front(); vectors++;
        if (cpu_read_data !== e32) begin miscompares++; $display("FAIL bp_cpu_data got %h want %h", cpu_read_data, e32); end
        @(posedge clk); #1;
        dma_data_ready = 1'b1;
        wait_done(200, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL bp_dma_timeout got none want dma_done"); end
        repeat (3) @(negedge clk);
        while (exp_mem.size() > 0 && obs_mem.size() > 0) begin
            e25 = exp_mem.pop_front(); o25 = obs_mem.pop_front(); vectors++;
            if (o25 !== e25) begin
                miscompares++;
                $display("FAIL bp_mem got cont=%b addr=%h want cont=%b addr=%h", o25[24], o25[23:0], e25[24], e25[23:0]);
            end
        end
        vectors++;
        if (obs_dma.size() != exp_dma.size()) begin
            miscompares++; $display("FAIL bp_word_count got %0d want %0d", obs_dma.size(), exp_dma.size());
        end
        while (exp_dma.size() > 0 && obs_dma.size() > 0) begin
            e32 = exp_dma.pop_front(); o32 = obs_dma.pop_front(); vectors++;
            if (o32 !== e32) begin miscompares++; $display("FAIL bp_word got %h want %h", o32, e32); end
        end
    endtask

    task automatic test_zero_and_ignored();
        bit ok;
        do_reset();
        start_dma(24'h120000, 16'd0, 1'b1);
        @(negedge clk);
        vectors++;
        if ({dma_done, dma_busy, mem_valid} !== 3'b100) begin
            miscompares++; $display("FAIL zero_done got done/busy/valid=%b want 100", {dma_done, dma_busy, mem_valid});
        end
        @(negedge clk);
        vectors++;
        if (dma_done !== 1'b0) begin miscompares++; $display("FAIL zero_pulse got %b want 0", dma_done); end
        repeat (4) @(negedge clk);
        vectors++;
        if (obs_mem.size() !== 0) begin miscompares++; $display("FAIL zero_no_access got %0d want 0", obs_mem.size()); end
        exp_mem.push_back({1'b0, 24'h200000});
        exp_mem.push_back({1'b1, 24'h200004});
        start_dma(24'h200000, 16'd2, 1'b1);
        start_dma(24'h300000, 16'd9, 1'b0);
        wait_done(200, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL ign_timeout got none want dma_done"); end
        repeat (6) @(negedge clk);
        vectors++;
        if (done_cnt !== 2) begin miscompares++; $display("FAIL ign_done_count got %0d want 2", done_cnt); end
        vectors++;
        if (obs_mem.size() != exp_mem.size()) begin
            miscompares++; $display("FAIL ign_mem_count got %0d want %0d", obs_mem.size(), exp_mem.size());
        end
        while (exp_mem.size() > 0 && obs_mem.size() > 0) begin
            e25 = exp_mem.pop_front(); o25 = obs_mem.pop_front(); vectors++;
            if (o25 !== e25) begin
                miscompares++;
                $display("FAIL ign_mem got cont=%b addr=%h want cont=%b addr=%h", o25[24], o25[23:0], e25[24], e25[23:0]);
            end
        end
        while (exp_dma.size() > 0 && obs_dma.size() > 0) begin
            e32 = exp_dma.pop_front(); o32 = obs_dma.pop_front(); vectors++;
            if (o32 !== e32) begin miscompares++; $display("FAIL ign_word got %h want %h", o32, e32); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        exp_mem.push_back({1'b0, 24'hFFFFF8});
        exp_mem.push_back({1'b1, 24'hFFFFFC});
        exp_mem.push_back({1'b1, 24'h000000});
        exp_mem.push_back({1'b1, 24'h000004});
        exp_mem.push_back({1'b1, 24'h000008});
        start_dma(24'hFFFFF8, 16'd3, 1'b1);
        wait_done(200, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL b2b_first_timeout got none want dma_done"); end
        dma_start = 1'b1; dma_address = 24'h000004; dma_length = 16'd2;
        exp_dma.push_back(flash_word(24'h000004));
        exp_dma.push_back(flash_word(24'h000008));
        @(posedge clk); #1;
        dma_start = 1'b0;
        @(negedge clk);
        vectors++;
        if (dma_busy !== 1'b1) begin miscompares++; $display("FAIL b2b_restart got busy=%b want 1", dma_busy); end
        wait_done(200, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL b2b_second_timeout got none want dma_done"); end
        repeat (3) @(negedge clk);
        vectors++;
        if (done_cnt !== 2) begin miscompares++; $display("FAIL b2b_done_count got %0d want 2", done_cnt); end
        vectors++;
        if (obs_mem.size() != exp_mem.size()) begin
            miscompares++; $display("FAIL b2b_mem_count got %0d want %0d", obs_mem.size(), exp_mem.size());
        end
        while (exp_mem.size() > 0 && obs_mem.size() > 0) begin
            e25 = exp_mem.pop_front(); o25 = obs_mem.pop_front(); vectors++;
            if (o25 !== e25) begin
                miscompares++;
                $display("FAIL b2b_mem got cont=%b addr=%h want cont=%b addr=%h", o25[24], o25[23:0], e25[24], e25[23:0]);
            end
        end
        vectors++;
        if (obs_dma.size() != exp_dma.size()) begin
            miscompares++; $display("FAIL b2b_word_count got %0d want %0d", obs_dma.size(), exp_dma.size());
        end
        while (exp_dma.size() > 0 && obs_dma.size() > 0) begin
            e32 = exp_dma.pop_front(); o32 = obs_dma.pop_front(); vectors++;
            if (o32 !== e32) begin miscompares++; $display("FAIL b2b_word got %h want %h", o32, e32); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok; int lat;
        do_reset();
        exp_mem.push_back({1'b0, 24'h100000});
        exp_mem.push_back({1'b0, 24'h100004});
        cpu_read(24'h100000, ok, lat);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL rmid_cpu1_timeout got none want cpu_read_ready"); end
        start_dma(24'h100004, 16'd4, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_valid) begin ok = 1'b1; break; end
        end
        vectors++;
        if (!ok || mem_continue !== 1'b1) begin
            miscompares++; $display("FAIL rmid_dma_req got valid=%b cont=%b want valid=1 cont=1", ok, mem_continue);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({mem_valid, mem_continue, cpu_read_ready, dma_busy, dma_data_valid, dma_done} !== 6'b0 ||
            {cpu_read_data, dma_data} !== 64'b0) begin
            miscompares++;
            $display("FAIL rmid_outputs got ctrl=%b data=%h want 0",
                     {mem_valid, mem_continue, cpu_read_ready, dma_busy, dma_data_valid, dma_done}, {cpu_read_data, dma_data});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        cpu_read(24'h100004, ok, lat);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL rmid_cpu2_timeout got none want cpu_read_ready"); end
        repeat (3) @(negedge clk);
        vectors++;
        if (obs_mem.size() != exp_mem.size()) begin
            miscompares++; $display("FAIL rmid_mem_count got %0d want %0d", obs_mem.size(), exp_mem.size());
        end
        while (exp_mem.size() > 0 && obs_mem.size() > 0) begin
            e25 = exp_mem.pop_front(); o25 = obs_mem.pop_front(); vectors++;
            if (o25 !== e25) begin
                miscompares++;
                $display("FAIL rmid_mem got cont=%b addr=%h want cont=%b addr=%h", o25[24], o25[23:0], e25[24], e25[23:0]);
            end
        end
        vectors++;
        if (obs_dma.size() !== 0) begin miscompares++; $display("FAIL rmid_no_dma got %0d words want 0", obs_dma.size()); end
        while (exp_cpu.size() > 0 && obs_cpu.size() > 0) begin
            e32 = exp_cpu.pop_front(); o32 = obs_cpu.pop_front(); vectors++;
            if (o32 !== e32) begin miscompares++; $display("FAIL rmid_cpu got %h want %h", o32, e32); end
        end
    endtask

    initial begin
        reset = 1'b1; cpu_read_en = 1'b0; cpu_address = '0;
        dma_start = 1'b0; dma_address = '0; dma_length = '0; dma_data_ready = 1'b1;
        test_reset();
        test_cpu_only();
        test_dma_burst();
        test_contention();
        test_backpressure();
        test_zero_and_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
